// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states, opcode
// encodings, instruction classes and datapath select codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CL_R,
        CL_IMM,
        CL_BR,
        CL_JMP,
        CL_LD,
        CL_ST,
        CL_ILL
    } op_class_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000110;
    localparam logic [5:0] OP_ANDI = 6'b000111;
    localparam logic [5:0] OP_SUBI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001001;
    localparam logic [5:0] OP_BEQ  = 6'b001010;
    localparam logic [5:0] OP_BNEQ = 6'b001011;
    localparam logic [5:0] OP_BGEZ = 6'b001100;
    localparam logic [5:0] OP_SLTI = 6'b001101;
    localparam logic [5:0] OP_LH   = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SB   = 6'b010000;
    localparam logic [5:0] OP_SH   = 6'b010001;
    localparam logic [5:0] OP_SW   = 6'b010010;
    localparam logic [5:0] OP_LUI  = 6'b010011;
    localparam logic [5:0] OP_LB   = 6'b010100;
    localparam logic [5:0] OP_J    = 6'b010101;
    localparam logic [5:0] OP_JR   = 6'b010110;
    localparam logic [5:0] OP_JAL  = 6'b010111;

    // Read and write buses use different width encodings
    localparam logic [1:0] MR_HALF = 2'b01;
    localparam logic [1:0] MR_WORD = 2'b10;
    localparam logic [1:0] MR_BYTE = 2'b11;
    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_WORD = 2'b11;

    localparam logic [1:0] AS_REG  = 2'b00;
    localparam logic [1:0] AS_IMM  = 2'b01;
    localparam logic [1:0] AS_BR   = 2'b10;
    localparam logic [1:0] AS_ADDR = 2'b11;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decode: instruction class, memory width code for the
// relevant bus, and legality.
module opcode_classifier
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    output op_class_e      op_class,
    output logic [1:0]     mem_code,
    output logic           legal
);

    logic [5:0] op6;
    logic       upper_set;

    assign op6       = opcode[5:0];
    assign upper_set = |(opcode >> 6);

    always_comb begin
        op_class = CL_ILL;
        mem_code = '0;
        if (!upper_set) begin
            case (op6)
                OP_R:                                         op_class = CL_R;
                OP_ADDI, OP_ANDI, OP_SUBI, OP_ORI, OP_SLTI,
                OP_LUI:                                       op_class = CL_IMM;
                OP_BEQ, OP_BNEQ, OP_BGEZ:                     op_class = CL_BR;
                OP_J, OP_JR, OP_JAL:                          op_class = CL_JMP;
                OP_LH: begin op_class = CL_LD; mem_code = MR_HALF; end
                OP_LW: begin op_class = CL_LD; mem_code = MR_WORD; end
                OP_LB: begin op_class = CL_LD; mem_code = MR_BYTE; end
                OP_SB: begin op_class = CL_ST; mem_code = MW_BYTE; end
                OP_SH: begin op_class = CL_ST; mem_code = MW_HALF; end
                OP_SW: begin op_class = CL_ST; mem_code = MW_WORD; end
                default:                                      op_class = CL_ILL;
            endcase
        end
        legal = (op_class != CL_ILL);
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// ready stalls, wait timeout and illegal-opcode detection.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW         = 6,
    parameter int unsigned ALUOPW      = 6,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPW-1:0]    opcode,
    input  logic              mem_ready,
    output logic              imem_req,
    output logic              ir_write,
    output logic              pc_write,
    output logic              reg_dst,
    output logic              jump,
    output logic              branch,
    output logic [1:0]        mem_read,
    output logic [1:0]        mem_write,
    output logic              mem_to_reg,
    output logic [ALUOPW-1:0] alu_op,
    output logic [1:0]        alu_src,
    output logic              reg_write,
    output logic              illegal_op,
    output logic              timeout,
    output logic [2:0]        state_o
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    state_e          state, state_next;
    logic [OPW-1:0]  ir_op;
    logic [CW-1:0]   wait_cnt;
    op_class_e       op_class;
    logic [1:0]      mem_code;
    logic            legal;
    logic            waiting, hit_timeout, is_jal;
    logic [ALUOPW-1:0] alu_val;

    opcode_classifier #(.OPW(OPW)) u_classifier (
        .opcode   (ir_op),
        .op_class (op_class),
        .mem_code (mem_code),
        .legal    (legal)
    );

    assign waiting     = (state == ST_FETCH || state == ST_MEM) && !mem_ready;
    assign hit_timeout = waiting && (wait_cnt == CW'(MEM_TIMEOUT));
    assign is_jal      = (ir_op[5:0] == OP_JAL);
    assign alu_val     = (op_class == CL_R) ? '1 : ALUOPW'(ir_op[5:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            ir_op    <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_FETCH && mem_ready)
                ir_op <= opcode;
            // A timeout in FETCH keeps the state, so it must clear explicitly
            if (state_next != state || hit_timeout)
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:  if (mem_ready) state_next = ST_DECODE;
            ST_DECODE: state_next = legal ? ST_EXEC : ST_FETCH;
            ST_EXEC: begin
                case (op_class)
                    CL_R, CL_IMM: state_next = ST_WB;
                    CL_LD, CL_ST: state_next = ST_MEM;
                    CL_JMP:       state_next = is_jal ? ST_WB : ST_FETCH;
                    default:      state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready)
                    state_next = (op_class == CL_LD) ? ST_WB : ST_FETCH;
                else if (hit_timeout)
                    state_next = ST_FETCH;
            end
            default:   state_next = ST_FETCH;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_dst    = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        mem_read   = '0;
        mem_write  = '0;
        mem_to_reg = 1'b0;
        alu_op     = '0;
        alu_src    = AS_REG;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        timeout    = 1'b0;
        state_o    = '0;
        // Outputs are forced low throughout reset, not only after the edge
        if (rst_n) begin
            state_o = state;
            timeout = hit_timeout;
            case (state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                ST_DECODE: illegal_op = !legal;
                ST_EXEC: begin
                    alu_op = alu_val;
                    case (op_class)
                        CL_JMP:       begin jump = 1'b1; pc_write = 1'b1; end
                        CL_BR:        begin branch = 1'b1; alu_src = AS_BR; end
                        CL_IMM:       alu_src = AS_IMM;
                        CL_LD, CL_ST: alu_src = AS_ADDR;
                        default:      alu_src = AS_REG;
                    endcase
                end
                ST_MEM: begin
                    alu_op = alu_val;
                    if (op_class == CL_LD) mem_read  = mem_code;
                    if (op_class == CL_ST) mem_write = mem_code;
                end
                ST_WB: begin
                    alu_op     = alu_val;
                    reg_write  = 1'b1;
                    mem_to_reg = (op_class == CL_LD);
                    reg_dst    = (op_class != CL_R);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed vector bench for multicycle_control_unit: table of per-cycle
// inputs and hand-computed outputs, plus timeout sequences.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [2:0] st;
        logic       imem;
        logic       irw;
        logic       pcw;
        logic       rdst;
        logic       jmp;
        logic       br;
        logic [1:0] mr;
        logic [1:0] mw;
        logic       m2r;
        logic [5:0] aluop;
        logic [1:0] asrc;
        logic       rw;
        logic       ill;
        logic       to;
    } outs_t;

    typedef struct {
        logic       r;
        logic [5:0] op;
        logic       rdy;
        outs_t      exp;
        string      name;
    } vec_t;

    localparam logic [5:0] ADDI = 6'b000110;
    localparam logic [5:0] LW   = 6'b001111;
    localparam logic [5:0] SW   = 6'b010010;
    localparam logic [5:0] SB   = 6'b010000;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b001010;
    localparam logic [5:0] JJ   = 6'b010101;
    localparam logic [5:0] JAL  = 6'b010111;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       imem_req, ir_write, pc_write, reg_dst, jump, branch;
    logic [1:0] mem_read, mem_write, alu_src;
    logic       mem_to_reg, reg_write, illegal_op, timeout;
    logic [5:0] alu_op;
    logic [2:0] state_o;
    outs_t      act;

    int unsigned tests = 0;
    int unsigned fails = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(.OPW(6), .ALUOPW(6), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .reg_dst(reg_dst), .jump(jump), .branch(branch),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
        .illegal_op(illegal_op), .timeout(timeout), .state_o(state_o)
    );

    assign act = {state_o, imem_req, ir_write, pc_write, reg_dst, jump, branch,
                  mem_read, mem_write, mem_to_reg, alu_op, alu_src,
                  reg_write, illegal_op, timeout};

    function automatic outs_t Z();
        outs_t o = '0;
        return o;
    endfunction

    function automatic outs_t F(logic rdy);
        outs_t o = '0;
        o.imem = 1'b1; o.irw = rdy; o.pcw = rdy;
        return o;
    endfunction

    function automatic outs_t D(logic ill);
        outs_t o = '0;
        o.st = 3'd1; o.ill = ill;
        return o;
    endfunction

    function automatic outs_t E(logic [5:0] a, logic [1:0] s, logic j, logic b);
        outs_t o = '0;
        o.st = 3'd2; o.aluop = a; o.asrc = s; o.jmp = j; o.pcw = j; o.br = b;
        return o;
    endfunction

    function automatic outs_t M(logic [5:0] a, logic [1:0] mr, logic [1:0] mw, logic to);
        outs_t o = '0;
        o.st = 3'd3; o.aluop = a; o.mr = mr; o.mw = mw; o.to = to;
        return o;
    endfunction

    function automatic outs_t W(logic [5:0] a, logic rdst, logic m2r);
        outs_t o = '0;
        o.st = 3'd4; o.aluop = a; o.rw = 1'b1; o.rdst = rdst; o.m2r = m2r;
        return o;
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                       input outs_t e, input string n);
        vec_t v;
        v.r = r; v.op = op; v.rdy = rdy; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                        input outs_t e, input string n);
        @(negedge clk);
        rst_n = r; opcode = op; mem_ready = rdy;
        #1;
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, e);
        end
    endtask

    initial begin
        outs_t e;

        add(0, RT, 0, Z(), "reset0");
        add(0, RT, 0, Z(), "reset1");
        add(1, RT, 0, F(0), "first_fetch_idle");
        // ADDI: 4 cycles, reg_write only in WB
        add(1, ADDI, 1, F(1), "addi_f");
        add(1, ADDI, 0, D(0), "addi_d");
        add(1, ADDI, 0, E(ADDI, 2'b01, 0, 0), "addi_e");
        add(1, ADDI, 0, W(ADDI, 1, 0), "addi_w");
        // LW with three stall cycles in MEM
        add(1, LW, 1, F(1), "lw_f");
        add(1, LW, 0, D(0), "lw_d");
        add(1, LW, 0, E(LW, 2'b11, 0, 0), "lw_e");
        add(1, LW, 0, M(LW, 2'b10, 2'b00, 0), "lw_m0");
        add(1, LW, 0, M(LW, 2'b10, 2'b00, 0), "lw_m1");
        add(1, LW, 0, M(LW, 2'b10, 2'b00, 0), "lw_m2");
        add(1, LW, 1, M(LW, 2'b10, 2'b00, 0), "lw_m3");
        add(1, LW, 0, W(LW, 1, 1), "lw_w");
        // Stores
        add(1, SW, 1, F(1), "sw_f");
        add(1, SW, 0, D(0), "sw_d");
        add(1, SW, 0, E(SW, 2'b11, 0, 0), "sw_e");
        add(1, SW, 1, M(SW, 2'b00, 2'b11, 0), "sw_m");
        add(1, SB, 1, F(1), "sb_f");
        add(1, SB, 0, D(0), "sb_d");
        add(1, SB, 0, E(SB, 2'b11, 0, 0), "sb_e");
        add(1, SB, 1, M(SB, 2'b00, 2'b01, 0), "sb_m");
        // R-type, branch, jumps
        add(1, RT, 1, F(1), "r_f");
        add(1, RT, 0, D(0), "r_d");
        add(1, RT, 0, E(6'h3f, 2'b00, 0, 0), "r_e");
        add(1, RT, 0, W(6'h3f, 0, 0), "r_w");
        add(1, BEQ, 1, F(1), "beq_f");
        add(1, BEQ, 0, D(0), "beq_d");
        add(1, BEQ, 0, E(BEQ, 2'b10, 0, 1), "beq_e");
        add(1, JJ, 1, F(1), "j_f");
        add(1, JJ, 0, D(0), "j_d");
        add(1, JJ, 0, E(JJ, 2'b00, 1, 0), "j_e");
        add(1, JAL, 1, F(1), "jal_f");
        add(1, JAL, 0, D(0), "jal_d");
        add(1, JAL, 0, E(JAL, 2'b00, 1, 0), "jal_e");
        add(1, JAL, 0, W(JAL, 1, 0), "jal_w");
        // Illegal opcode returns to FETCH with no strobes
        add(1, BAD, 1, F(1), "ill_f");
        add(1, BAD, 0, D(1), "ill_d");
        add(1, BAD, 0, F(0), "ill_back_f");
        // Reset during a LW memory stall
        add(1, LW, 1, F(1), "rlw_f");
        add(1, LW, 0, D(0), "rlw_d");
        add(1, LW, 0, E(LW, 2'b11, 0, 0), "rlw_e");
        add(1, LW, 0, M(LW, 2'b10, 2'b00, 0), "rlw_m");
        add(0, LW, 0, Z(), "rlw_rst_during");
        add(0, LW, 0, Z(), "rlw_rst_after");
        add(1, ADDI, 1, F(1), "post_rst_f");
        add(1, ADDI, 0, D(0), "post_rst_d");
        add(1, ADDI, 0, E(ADDI, 2'b01, 0, 0), "post_rst_e");
        add(1, ADDI, 0, W(ADDI, 1, 0), "post_rst_w");

        foreach (vecs[i])
            step(vecs[i].r, vecs[i].op, vecs[i].rdy, vecs[i].exp,
                 $sformatf("%s[%0d]", vecs[i].name, i));

        // FETCH stall: timeout on the 16th wait cycle, then counting restarts
        for (int i = 0; i < 32; i++) begin
            e = F(0);
            e.to = (i == 15 || i == 31);
            step(1, LW, 0, e, $sformatf("fetch_wait%0d", i));
        end
        // mem_ready at the timeout cycle completes normally
        for (int i = 0; i < 15; i++)
            step(1, LW, 0, F(0), $sformatf("pre_win%0d", i));
        step(1, LW, 1, F(1), "ready_wins_timeout");
        step(1, LW, 0, D(0), "tlw_d");
        step(1, LW, 0, E(LW, 2'b11, 0, 0), "tlw_e");
        // MEM stall timeout aborts to FETCH without writeback
        for (int i = 0; i < 16; i++)
            step(1, LW, 0, M(LW, 2'b10, 2'b00, i == 15), $sformatf("mem_wait%0d", i));
        step(1, LW, 0, F(0), "after_mem_timeout");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
